// File: rtl/ss_pkg.sv
// Shared types and timing constants for the SS_cal_sum sequencer.
package ss_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StGap,
    StFetch,
    StDrain,
    StOut,
    StCapture,
    StResult
  } ss_sum_state_e;

  localparam int unsigned SS_START_CYCLES = 2;
  localparam int unsigned SS_GAP_CYCLES   = 1;
  localparam int unsigned SS_DRAIN_CYCLES = 2;

endpackage

// File: rtl/ss_sum_ctrl_if.sv
// Request, sample-source and result channels of the summation sequencer.
interface ss_sum_ctrl_if #(
  parameter int unsigned SIZE_DATA = 8,
  parameter int unsigned MAX_LEN   = 16
);
  localparam int unsigned LEN_W = $clog2(MAX_LEN + 1);

  logic                 i_req;
  logic [LEN_W-1:0]     i_len;
  logic                 o_busy;
  logic                 i_src_valid;
  logic [SIZE_DATA-1:0] i_src_data;
  logic                 o_src_ready;
  logic [SIZE_DATA:0]   o_result;
  logic                 o_result_err;
  logic                 o_result_valid;
  logic                 i_result_ready;

  modport master (
    output i_req, i_len, i_src_valid, i_src_data, i_result_ready,
    input  o_busy, o_src_ready, o_result, o_result_err, o_result_valid
  );

  modport slave (
    input  i_req, i_len, i_src_valid, i_src_data, i_result_ready,
    output o_busy, o_src_ready, o_result, o_result_err, o_result_valid
  );
endinterface

// File: rtl/ss_sum_cnt.sv
// Clearable up-counter; o_hit flags that the next count equals the limit.
module ss_sum_cnt #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_clr,
  input  logic             i_inc,
  input  logic [WIDTH-1:0] i_limit,
  output logic             o_hit
);
  logic [WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (i_clr) begin
      cnt_d = '0;
    end else if (i_inc) begin
      cnt_d = cnt_q + WIDTH'(1);
    end
  end

  assign o_hit = (cnt_d == i_limit);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/ss_sum_ctrl.sv
// Sequencer for the SS_cal_sum engine: pulls samples, paces start/add/output
// controls and returns the captured sum on a valid/ready result port.
module ss_sum_ctrl import ss_pkg::*; #(
  parameter int unsigned SIZE_DATA    = 8,
  parameter int unsigned MAX_LEN      = 16,
  parameter int unsigned DONE_TIMEOUT = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  ss_sum_ctrl_if.slave         bus,
  output logic                 o_start_cal_sum,
  output logic                 o_en_cal_sum,
  output logic                 o_en_out_sum,
  output logic [SIZE_DATA-1:0] o_cal_data,
  input  logic [SIZE_DATA:0]   i_cal_sum,
  input  logic                 i_cal_done
);
  localparam int unsigned LEN_W = $clog2(MAX_LEN + 1);
  localparam int unsigned TMO_W = $clog2(DONE_TIMEOUT + 1);

  ss_sum_state_e      state_q, state_d;
  logic [1:0]         phase_q, phase_d;
  logic [LEN_W-1:0]   len_q, len_d, len_clamped;
  logic [SIZE_DATA:0] result_d;
  logic               err_d;
  logic               accept, smp_hit, tmo_hit;

  assign accept      = bus.i_src_valid & bus.o_src_ready;
  assign len_clamped = (bus.i_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : bus.i_len;

  ss_sum_cnt #(.WIDTH(LEN_W)) u_smp_cnt (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_clr   (state_q == StIdle),
    .i_inc   (accept),
    .i_limit (len_q),
    .o_hit   (smp_hit)
  );

  ss_sum_cnt #(.WIDTH(TMO_W)) u_tmo_cnt (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_clr   (state_q != StOut),
    .i_inc   (state_q == StOut),
    .i_limit (TMO_W'(DONE_TIMEOUT)),
    .o_hit   (tmo_hit)
  );

  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    result_d = bus.o_result;
    err_d    = bus.o_result_err;
    case (state_q)
      StIdle: begin
        if (bus.i_req) begin
          len_d = len_clamped;
          if (len_clamped == '0) begin
            state_d  = StResult;
            result_d = '0;
            err_d    = 1'b0;
          end else begin
            state_d = StStart;
          end
        end
      end
      StStart:   if (phase_q == 2'(SS_START_CYCLES - 1)) state_d = StGap;
      StGap:     if (phase_q == 2'(SS_GAP_CYCLES - 1)) state_d = StFetch;
      StFetch:   if (accept && smp_hit) state_d = StDrain;
      StDrain:   if (phase_q == 2'(SS_DRAIN_CYCLES - 1)) state_d = StOut;
      StOut: begin
        if (i_cal_done) begin
          state_d = StCapture;
        end else if (tmo_hit) begin
          state_d  = StResult;
          result_d = i_cal_sum;
          err_d    = 1'b1;
        end
      end
      StCapture: begin
        state_d  = StResult;
        result_d = i_cal_sum;
        err_d    = 1'b0;
      end
      StResult:  if (bus.i_result_ready) state_d = StIdle;
      default:   state_d = StIdle;
    endcase
    phase_d = (state_d != state_q) ? 2'd0 : phase_q + 2'd1;
  end

  // Control outputs are decoded from the next state so they line up with it.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q            <= StIdle;
      phase_q            <= '0;
      len_q              <= '0;
      bus.o_busy         <= 1'b0;
      bus.o_src_ready    <= 1'b0;
      bus.o_result       <= '0;
      bus.o_result_err   <= 1'b0;
      bus.o_result_valid <= 1'b0;
      o_start_cal_sum    <= 1'b0;
      o_en_cal_sum       <= 1'b0;
      o_en_out_sum       <= 1'b0;
      o_cal_data         <= '0;
    end else begin
      state_q            <= state_d;
      phase_q            <= phase_d;
      len_q              <= len_d;
      bus.o_busy         <= (state_d != StIdle);
      bus.o_src_ready    <= (state_d == StFetch);
      bus.o_result       <= result_d;
      bus.o_result_err   <= err_d;
      bus.o_result_valid <= (state_d == StResult);
      o_start_cal_sum    <= (state_d == StStart);
      o_en_cal_sum       <= accept;
      o_en_out_sum       <= (state_d == StOut);
      if (accept) begin
        o_cal_data <= bus.i_src_data;
      end
    end
  end
endmodule

// File: doc/ss_sum_ctrl.md
# ss_sum_ctrl

Sequencer for the `SS_cal_sum` summation engine.
- Accepts a summation request of `i_len` samples and pulls those samples from a valid/ready source.
- Drives the engine's start, accumulate and output-enable controls with the required spacing, waits for the engine's done pulse, and returns the captured sum on a valid/ready result port.
- Sits between the sample stream and the engine, one engine per controller.

## Interface
- `SIZE_DATA`, 8, sample width; the sum is `SIZE_DATA+1` bits.
- `MAX_LEN`, 16, maximum samples per request; `LEN_W = $clog2(MAX_LEN+1)`.
- `DONE_TIMEOUT`, 8, cycles to wait for the engine's done pulse before flagging an error.

Ports:
- `i_clk` in 1: clock, single domain.
- `i_rst_n` in 1: reset, asynchronous, active-low.
- `i_req` in 1: request strobe, sampled in IDLE only.
- `i_len` in `LEN_W`: sample count, captured with `i_req`; values above `MAX_LEN` are clamped to `MAX_LEN`.
- `o_busy` out 1: high in every state except IDLE.
- `i_src_valid` in 1: source handshake, valid.
- `i_src_data` in `SIZE_DATA`: source sample.
- `o_src_ready` out 1: source handshake, ready.
- `o_start_cal_sum` out 1: to the engine.
- `o_en_cal_sum` out 1: to the engine.
- `o_en_out_sum` out 1: to the engine.
- `o_cal_data` out `SIZE_DATA`: to the engine.
- `i_cal_sum` in `SIZE_DATA+1`: from the engine.
- `i_cal_done` in 1: from the engine.
- `o_result` out `SIZE_DATA+1`: captured sum.
- `o_result_err` out 1: error flag qualified by `o_result_valid`.
- `o_result_valid` out 1: result handshake, valid.
- `i_result_ready` in 1: result handshake, ready.

## Operation
- All outputs are registered and reset to 0. Reset returns the FSM to IDLE.
- IDLE:
  - `i_req` → START; latch the clamped length and clear the counter.
  - If the latched length is 0 → RESULT with `o_result=0`, `o_result_err=0`; the engine is untouched.
- START, 2 cycles: `o_start_cal_sum=1`. The low-to-high transition clears the engine accumulator.
- GAP, 1 cycle: `o_start_cal_sum=0`. This guarantees the clear has landed before the first add.
- FETCH:
  - `o_src_ready=1`.
  - On each `i_src_valid&o_src_ready`, the next cycle carries `o_en_cal_sum=1` and `o_cal_data=i_src_data`; otherwise `o_en_cal_sum=0`.
  - The counter increments per accepted sample. Ready drops in the same cycle the count reaches the length (`ready = cnt < len` as a registered decision). No sample beyond the length is accepted.
- DRAIN, 2 cycles: `o_en_cal_sum` covers the last sample, then one settle cycle.
- OUT:
  - `o_en_out_sum=1`, held until `i_cal_done` is seen high. `o_en_out_sum` is low from the cycle after `i_cal_done`, so the engine's clear-on-done never reaches its output register.
  - Timeout counter increments per OUT cycle. Reaching `DONE_TIMEOUT` → RESULT with `o_result_err=1`, `o_result=i_cal_sum`, `o_en_out_sum` dropped.
- CAPTURE, 1 cycle, entered the cycle after `i_cal_done`: `o_result <= i_cal_sum`, `o_result_err <= 0`.
- RESULT: `o_result_valid=1`, result held stable; `i_result_ready` → IDLE.
- `i_src_valid` outside FETCH and `i_req` outside IDLE are ignored.
- `i_cal_done` outside OUT is ignored.
- Arithmetic: the sum wraps modulo `2^(SIZE_DATA+1)`. The controller does no overflow detection; at most 2 full-scale samples fit.

## Timing
- Cycle 0 is `i_req` in IDLE.
  - START: cycles 1–2.
  - GAP: cycle 3.
  - FETCH: from cycle 4.
- With a source valid every cycle and `len=N`:
  - Last accept at cycle 3+N.
  - DRAIN: cycles 4+N and 5+N.
  - OUT: from 6+N.
- With a 1-cycle engine done latency:
  - CAPTURE at 8+N.
  - `o_result_valid` at 9+N.
- Back-to-back: `i_req` is accepted in the first IDLE cycle after the RESULT handshake, giving a minimum 1-cycle IDLE gap.
- Source bubbles stretch FETCH only; all other state lengths are fixed.
- Asynchronous reset mid-FETCH or mid-OUT: outputs go to 0 immediately and the FSM enters IDLE. The next request's START re-clears the engine.

## Structure
- Shared package `ss_pkg` holds:
  - the state enum `ss_sum_state_e` (IDLE, START, GAP, FETCH, DRAIN, OUT, CAPTURE, RESULT);
  - the constants `SS_START_CYCLES=2`, `SS_GAP_CYCLES=1`, `SS_DRAIN_CYCLES=2`.
- One sub-module is natural: `ss_sum_cnt`, a loadable up-counter with compare. It is instantiated twice, once for the sample count and once for the timeout.
- The engine is not instantiated inside; it is connected at the parent level.

## Test plan
- Golden engine connected, `len=4`, data 10,20,30,40 with valid every cycle → `o_result=100`, err=0, valid at cycle 13.
- `len=3`, source valid on alternate cycles with data 255,255,255 → `o_result=765 mod 512 = 253`; `o_en_cal_sum` pulses exactly 3 times.
- `len=0` → `o_result_valid` within 2 cycles, `o_result=0`; the engine sees no start, enable or output-enable.
- Engine done tied low, `len=2` → `o_result_err=1` after `DONE_TIMEOUT` OUT cycles; `o_en_out_sum` is 0 afterwards.
- `i_result_ready` held low for 5 cycles with a new `i_req` pulsed meanwhile → result stable, request ignored; the next request is accepted after the handshake.
- `i_rst_n` asserted mid-FETCH, then `len=2` with data 1,2 → all outputs 0 during reset, next result 3.
